// File: rtl/seq_gen_ctrl_if.sv
// Bundle between seq_gen_ctrl and its host, data RAM, register file and ALU.
// master = environment side, slave = controller side.
interface seq_gen_ctrl_if #(
    parameter int DW  = 32,
    parameter int AW  = 6,
    parameter int OPW = 3
);
    logic           start;
    logic [AW-1:0]  len;
    logic [AW-1:0]  src_base;
    logic [AW-1:0]  dst_base;
    logic [OPW-1:0] op;
    logic           busy;
    logic           done;
    logic           err;
    logic [AW-1:0]  ram_ra;
    logic [DW-1:0]  ram_rd;
    logic           ram_we;
    logic [AW-1:0]  ram_wa;
    logic [DW-1:0]  ram_wd;
    logic           rf_we;
    logic [AW-1:0]  rf_wa;
    logic [DW-1:0]  rf_wd;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_y;
    logic           alu_ovf;

    modport master (
        output start, len, src_base, dst_base, op,
        output ram_rd, alu_y, alu_ovf,
        input  busy, done, err,
        input  ram_ra, ram_we, ram_wa, ram_wd,
        input  rf_we, rf_wa, rf_wd,
        input  alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, len, src_base, dst_base, op,
        input  ram_rd, alu_y, alu_ovf,
        output busy, done, err,
        output ram_ra, ram_we, ram_wa, ram_wd,
        output rf_we, rf_wa, rf_wd,
        output alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/seq_gen_ctrl.sv
// Sequence controller: x(n) = x(n-2) OP x(n-1) seeded from RAM, via external ALU.
// Optional SEQ_OVF_ABORT_EN: ALU overflow aborts the run and raises err.
module seq_gen_ctrl #(
    parameter int DW  = 32,
    parameter int AW  = 6,
    parameter int OPW = 3
) (
    input logic          clk,
    input logic          rst,
    seq_gen_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        CALC,
        DONE
    } state_t;

    state_t         state;
    logic           ph;
    logic [AW-1:0]  k;
    logic [AW-1:0]  j;
    logic [AW-1:0]  dst;
    logic [AW-1:0]  ra;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  x;
    logic [DW-1:0]  y;
    logic           busy;
    logic           done;
    logic           err;
    logic           ovf_abort;

`ifdef SEQ_OVF_ABORT_EN
    assign ovf_abort = bus.alu_ovf;
`else
    logic unused_ovf;
    assign unused_ovf = bus.alu_ovf;
    assign ovf_abort  = 1'b0;
`endif

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
    assign bus.ram_ra = ra;
    assign bus.alu_a  = x;
    assign bus.alu_b  = y;
    assign bus.alu_op = op_q;

    // Write strobes decode the current state so nothing is written after reset.
    always_comb begin
        bus.rf_we  = 1'b0;
        bus.rf_wa  = '0;
        bus.rf_wd  = '0;
        bus.ram_we = 1'b0;
        bus.ram_wa = '0;
        bus.ram_wd = '0;
        case (state)
            LDA: begin
                if (ph) begin
                    bus.rf_we = 1'b1;
                    bus.rf_wd = bus.ram_rd;
                end
            end
            LDB: begin
                bus.rf_we = 1'b1;
                bus.rf_wa = AW'(1);
                bus.rf_wd = bus.ram_rd;
            end
            CALC: begin
                if (!ovf_abort) begin
                    bus.rf_we  = 1'b1;
                    bus.rf_wa  = j + AW'(2);
                    bus.rf_wd  = bus.alu_y;
                    bus.ram_we = 1'b1;
                    bus.ram_wa = dst + j;
                    bus.ram_wd = bus.alu_y;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph    <= 1'b0;
            k     <= '0;
            j     <= '0;
            dst   <= '0;
            ra    <= '0;
            op_q  <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (bus.start && !busy) begin
                        k     <= bus.len;
                        dst   <= bus.dst_base;
                        op_q  <= bus.op;
                        ra    <= bus.src_base;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        j     <= '0;
                        ph    <= 1'b0;
                        state <= LDA;
                    end
                end
                // First LDA cycle waits out the RAM read latency of seed a.
                LDA: begin
                    if (!ph) begin
                        ph <= 1'b1;
                        ra <= ra + AW'(1);
                    end else begin
                        x     <= bus.ram_rd;
                        state <= LDB;
                    end
                end
                LDB: begin
                    y     <= bus.ram_rd;
                    state <= (k == '0) ? DONE : CALC;
                end
                CALC: begin
                    if (ovf_abort) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        x <= y;
                        y <= bus.alu_y;
                        if (j == k - AW'(1)) begin
                            state <= DONE;
                        end else begin
                            j <= j + AW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Bench for seq_gen_ctrl: RAM/RF/ALU models plus a term-list reference model.
module tb_seq_gen_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 64;
`ifdef SEQ_OVF_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic init;
    logic pl_we;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rf [N];
    logic [DW-1:0] exp_mem [N];
    logic [DW-1:0] exp_rf [N];
    int npass = 0;
    int ntot = 0;

    seq_gen_ctrl_if #(.DW(DW), .AW(AW), .OPW(3)) bus ();

    seq_gen_ctrl #(.DW(DW), .AW(AW), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i, input bit r);
        logic [DW-1:0] v;
        v = DW'(i) * 32'h9E37_79B9 + 32'h1234;
        return r ? ~v : v;
    endfunction

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, b,
                                            input logic [2:0] o);
        case (o)
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic alu_v(input logic [DW-1:0] a, b,
                                   input logic [2:0] o);
        logic [DW-1:0] r;
        r = alu_f(a, b, o);
        case (o)
            3'd0: return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            3'd1: return (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            default: return 1'b0;
        endcase
    endfunction

    assign bus.alu_y   = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_ovf = alu_v(bus.alu_a, bus.alu_b, bus.alu_op);

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < N; i++) mem[i] <= pat(i, 1'b0);
        end else if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (bus.ram_we) begin
            mem[bus.ram_wa] <= bus.ram_wd;
        end
        bus.ram_rd <= mem[bus.ram_ra];
    end

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < N; i++) rf[i] <= pat(i, 1'b1);
        end else if (bus.rf_we) begin
            rf[bus.rf_wa] <= bus.rf_wd;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic run(input string nm, input logic [DW-1:0] a, b,
                       input logic [2:0] o, input int k,
                       input logic [AW-1:0] src, dst, input bit restart);
        logic [DW-1:0] x, y, t;
        int terms, exp_done, done_at, dcnt, nrf, nram, stray, mis_rf, mis_ram;
        bit ab;
        logic busy0;
        @(negedge clk);
        pl_we = 1'b1; pl_a = src; pl_d = a;
        @(negedge clk);
        pl_a = src + AW'(1); pl_d = b;
        @(negedge clk);
        pl_we = 1'b0;
        exp_mem[src] = a;
        exp_mem[src + AW'(1)] = b;
        // Reference: unroll the recurrence as a plain term list
        x = a; y = b; terms = 0; ab = 1'b0;
        exp_rf[0] = a; exp_rf[1] = b;
        for (int n = 0; n < k; n++) begin
            t = alu_f(x, y, o);
            if (ABORT && alu_v(x, y, o)) begin
                ab = 1'b1;
                break;
            end
            exp_rf[AW'(n + 2)] = t;
            exp_mem[AW'(dst + n)] = t;
            terms++;
            x = y; y = t;
        end
        exp_done = ab ? terms + 5 : k + 4;
        bus.start = 1'b1; bus.len = AW'(k); bus.op = o;
        bus.src_base = src; bus.dst_base = dst;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.len = AW'($urandom);
        bus.op = 3'($urandom);
        bus.src_base = AW'($urandom);
        bus.dst_base = AW'($urandom);
        done_at = -1; dcnt = 0; nrf = 0; nram = 0; stray = 0; busy0 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) busy0 = bus.busy;
            if (bus.done) begin
                dcnt++;
                if (done_at < 0) done_at = i;
            end
            if (bus.rf_we) nrf++;
            if (bus.ram_we) nram++;
            if ((bus.rf_we || bus.ram_we) && !bus.busy) stray++;
            bus.start = (restart && i == 1);
            if (done_at >= 0 && i >= done_at + 2) break;
        end
        chk({nm, "_done_at"}, done_at, exp_done);
        chk({nm, "_done_cnt"}, dcnt, 1);
        chk({nm, "_rf_writes"}, nrf, 2 + terms);
        chk({nm, "_ram_writes"}, nram, terms);
        chk({nm, "_stray_we"}, stray, 0);
        chk({nm, "_busy_start"}, busy0, 1);
        chk({nm, "_busy_end"}, bus.busy, 0);
        chk({nm, "_err"}, bus.err, ab);
        mis_rf = 0; mis_ram = 0;
        for (int i = 0; i < N; i++) begin
            if (rf[i] !== exp_rf[i]) mis_rf++;
            if (mem[i] !== exp_mem[i]) mis_ram++;
        end
        chk({nm, "_rf_image"}, mis_rf, 0);
        chk({nm, "_ram_image"}, mis_ram, 0);
    endtask

    task automatic run_rst();
        int nw, dcnt;
        logic [255:0] outs;
        @(negedge clk);
        bus.start = 1'b1; bus.len = AW'(5); bus.op = 3'd0;
        bus.src_base = AW'(20); bus.dst_base = AW'(40);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i <= 5; i++) @(negedge clk);
        chk("rst_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        outs = {bus.busy, bus.done, bus.err, bus.ram_ra, bus.ram_we, bus.ram_wa,
                bus.ram_wd, bus.rf_we, bus.rf_wa, bus.rf_wd, bus.alu_a,
                bus.alu_b, bus.alu_op};
        chk("rst_outs_zero", (outs != '0), 0);
        nw = 0; dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (bus.rf_we || bus.ram_we) nw++;
            if (bus.done) dcnt++;
        end
        chk("rst_writes_after", nw, 0);
        chk("rst_no_done", dcnt, 0);
        chk("rst_busy_after", bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1; init = 1'b1; pl_we = 1'b0; pl_a = '0; pl_d = '0;
        bus.start = 1'b0; bus.len = '0; bus.op = '0;
        bus.src_base = '0; bus.dst_base = '0;
        for (int i = 0; i < N; i++) begin
            exp_mem[i] = pat(i, 1'b0);
            exp_rf[i] = pat(i, 1'b1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_ra", bus.ram_ra, 0);
        chk("reset_we", {bus.rf_we, bus.ram_we}, 0);
        rst = 1'b0;
        run("fib", 32'd1, 32'd1, 3'd0, 3, AW'(0), AW'(2), 1'b0);
        chk("fib_ram4", mem[4], 5);
        chk("fib_rf4", rf[4], 5);
        run("k0", 32'd7, 32'd9, 3'd0, 0, AW'(5), AW'(30), 1'b0);
        run("wrap", 32'd1, 32'd2, 3'd0, 3, AW'(10), AW'(62), 1'b0);
        chk("wrap_ram0", mem[0], 8);
        run("restart", 32'd3, 32'd4, 3'd1, 3, AW'(12), AW'(50), 1'b1);
        run("ovf", 32'h7000_0000, 32'h7000_0000, 3'd0, 4, AW'(14), AW'(20), 1'b0);
        run("long", 32'd2, 32'd5, 3'd4, 63, AW'(60), AW'(33), 1'b0);
        for (int r = 0; r < 6; r++) begin
            run($sformatf("rnd%0d", r), $urandom, $urandom, 3'($urandom_range(0, 4)),
                $urandom_range(0, 20), AW'($urandom), AW'($urandom), r[0]);
        end
        run_rst();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
